// File: rtl/sequential_multiplier.sv
// rtl/sequential_multiplier.sv - multi-cycle shift-and-add multiplier with Start/Busy/Done handshake
//
// Purpose: computes the full 2*WIDTH-bit product of A and B with one multiplier
//          bit retired per clock. The result and Overflow are registered once,
//          in the edge that enters DONE, and then hold until the next DONE.
// Optional: define SEQUENTIAL_MULTIPLIER_SIGNED_EN to add the Signed input
//          (two's complement operands when Signed=1).
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous active-high reset
//   Start        in   request a multiply (ignored while Busy)
//   Signed       in   (SEQUENTIAL_MULTIPLIER_SIGNED_EN only) operands are signed
//   A, B         in   multiplicand / multiplier, captured on accepted Start
//   Busy         out  high while iterating (WIDTH cycles)
//   Done         out  one-cycle pulse when the product outputs update
//   ProductHigh  out  upper WIDTH bits of the product
//   ProductLow   out  lower WIDTH bits of the product
//   Overflow     out  product does not fit in WIDTH bits

module sequential_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
`ifdef SEQUENTIAL_MULTIPLIER_SIGNED_EN
    input  logic             Signed,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ProductHigh,
    output logic [WIDTH-1:0] ProductLow,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               neg;
    logic               sgn_mode;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_in;
    logic               sgn_in;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic               ovf;

    // Start is honoured in IDLE and in DONE (back-to-back), never in RUN.
    assign accept = Start && (state != RUN);
    assign last   = (state == RUN) && (count == CW'(WIDTH - 1));

    // Operand conditioning: the iteration always works on magnitudes; the sign
    // of the result is remembered and applied on the final edge.
`ifdef SEQUENTIAL_MULTIPLIER_SIGNED_EN
    always_comb begin
        sgn_in = Signed;
        a_mag  = (Signed && A[WIDTH-1]) ? -A : A;
        b_mag  = (Signed && B[WIDTH-1]) ? -B : B;
        neg_in = Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
    end
`else
    always_comb begin
        sgn_in = 1'b0;
        a_mag  = A;
        b_mag  = B;
        neg_in = 1'b0;
    end
`endif

    // One shift-and-add step. The adder is WIDTH+1 bits wide so its carry
    // lands in the accumulator MSB after the right shift.
    always_comb begin
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_step  = {upper_sum, acc[WIDTH-1:1]};
        prod      = neg ? -acc_step : acc_step;
        if (sgn_mode) begin
            ovf = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        end else begin
            ovf = (prod[2*WIDTH-1:WIDTH] != '0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = Start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            count       <= '0;
            neg         <= 1'b0;
            sgn_mode    <= 1'b0;
            ProductHigh <= '0;
            ProductLow  <= '0;
            Overflow    <= 1'b0;
        end else if (accept) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            acc      <= '0;
            count    <= '0;
            neg      <= neg_in;
            sgn_mode <= sgn_in;
        end else if (state == RUN) begin
            acc    <= acc_step;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            // Outputs only ever see the completed product, never partials.
            if (last) begin
                ProductHigh <= prod[2*WIDTH-1:WIDTH];
                ProductLow  <= prod[WIDTH-1:0];
                Overflow    <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// tb/tb_sequential_multiplier.sv - self-checking bench for sequential_multiplier

module tb_sequential_multiplier;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        signed_in;
    logic [15:0] A;
    logic [15:0] B;
    logic        Busy;
    logic        Done;
    logic [15:0] ProductHigh;
    logic [15:0] ProductLow;
    logic        Overflow;
    bit          clk_run;

    int checks = 0;
    int errors = 0;

    sequential_multiplier #(.WIDTH(16)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
`ifdef SEQUENTIAL_MULTIPLIER_SIGNED_EN
        .Signed      (signed_in),
`endif
        .A           (A),
        .B           (B),
        .Busy        (Busy),
        .Done        (Done),
        .ProductHigh (ProductHigh),
        .ProductLow  (ProductLow),
        .Overflow    (Overflow)
    );

    initial Clock = 1'b0;
    always begin
        #5;
        if (clk_run) Clock = ~Clock;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        ov;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands as numbers.
    function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [31:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ov;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
            ov = (p[31:16] != {16{p[15]}});
        end else begin
            p  = {16'd0, a} * {16'd0, b};
            ov = (p[31:16] != 16'd0);
        end
        return {ov, p};
    endfunction

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge Clock);
        A = a;
        B = b;
        signed_in = s;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles, output bit got);
        busy_cycles = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done) begin
                got = 1'b1;
                break;
            end
            if (Busy) busy_cycles++;
            @(negedge Clock);
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] hi, input logic [15:0] lo,
                          input logic ov);
        int bc;
        bit got;
        start_op(a, b, s);
        wait_done(bc, got);
        check({name, ".done"}, 64'(got), 64'd1);
        check({name, ".busy_cycles"}, 64'(bc), 64'd16);
        check({name, ".result"}, {31'd0, Overflow, ProductHigh, ProductLow}, {31'd0, ov, hi, lo});
        @(negedge Clock);
        check({name, ".done_pulse"}, 64'(Done), 64'd0);
        @(negedge Clock);
        check({name, ".hold"}, {31'd0, Overflow, ProductHigh, ProductLow}, {31'd0, ov, hi, lo});
    endtask

    initial begin
        int          bc;
        bit          got;
        int          dones;
        int          done_at[$];
        bit          busy_bad;
        logic [32:0] m;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [47:0] first_res;

        clk_run   = 1'b0;
        Reset     = 1'b0;
        Start     = 1'b0;
        signed_in = 1'b0;
        A         = '0;
        B         = '0;

        // Reset with the clock stopped: outputs must clear without an edge.
        #2 Reset = 1'b1;
        #1 check("reset_no_clock", {Busy, Done, Overflow, ProductHigh, ProductLow}, 64'd0);
        clk_run = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        vecs.push_back('{a: 16'd5,      b: 16'd2,      s: 1'b0, hi: 16'h0000, lo: 16'h000A, ov: 1'b0});
        vecs.push_back('{a: 16'hFFFF,   b: 16'hFFFF,   s: 1'b0, hi: 16'hFFFE, lo: 16'h0001, ov: 1'b1});
        vecs.push_back('{a: 16'd18,     b: 16'd0,      s: 1'b0, hi: 16'h0000, lo: 16'h0000, ov: 1'b0});
        vecs.push_back('{a: 16'd0,      b: 16'hFFFF,   s: 1'b0, hi: 16'h0000, lo: 16'h0000, ov: 1'b0});
        vecs.push_back('{a: 16'd1000,   b: 16'd1000,   s: 1'b0, hi: 16'h000F, lo: 16'h4240, ov: 1'b1});
        vecs.push_back('{a: 16'h8000,   b: 16'd2,      s: 1'b0, hi: 16'h0001, lo: 16'h0000, ov: 1'b1});
        vecs.push_back('{a: 16'd255,    b: 16'd257,    s: 1'b0, hi: 16'h0000, lo: 16'hFFFF, ov: 1'b0});
`ifdef SEQUENTIAL_MULTIPLIER_SIGNED_EN
        vecs.push_back('{a: 16'hFFFD,   b: 16'd5,      s: 1'b1, hi: 16'hFFFF, lo: 16'hFFF1, ov: 1'b0});
        vecs.push_back('{a: 16'h8000,   b: 16'h8000,   s: 1'b1, hi: 16'h4000, lo: 16'h0000, ov: 1'b1});
        vecs.push_back('{a: 16'hFFFF,   b: 16'hFFFF,   s: 1'b1, hi: 16'h0000, lo: 16'h0001, ov: 1'b0});
        vecs.push_back('{a: 16'hFFFD,   b: 16'd5,      s: 1'b0, hi: 16'h0004, lo: 16'hFFF1, ov: 1'b1});
`endif
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                   vecs[i].hi, vecs[i].lo, vecs[i].ov);
        end

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            logic rs;
            ra = 16'($urandom);
            rb = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom);
`ifdef SEQUENTIAL_MULTIPLIER_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rs);
            run_op($sformatf("rand%0d", i), ra, rb, rs, m[31:16], m[15:0], m[32]);
        end

        // Start re-pulsed in RUN cycle 5 must be ignored.
        start_op(16'd18, 16'd3, 1'b0);
        repeat (4) @(negedge Clock);
        A = 16'd7;
        B = 16'd7;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        dones = 0;
        first_res = '0;
        for (int i = 0; i < 30; i++) begin
            if (Done) begin
                if (dones == 0) first_res = {15'd0, Overflow, ProductHigh, ProductLow};
                dones++;
            end
            @(negedge Clock);
        end
        check("repulse.dones", 64'(dones), 64'd1);
        check("repulse.result", 64'(first_res), 64'h36);

        // Start held high: back-to-back results every 17 cycles.
        @(negedge Clock);
        A = 16'd300;
        B = 16'd300;
        Start = 1'b1;
        @(negedge Clock);
        busy_bad = 1'b0;
        for (int i = 0; i <= 50; i++) begin
            if (Busy == Done) busy_bad = 1'b1;
            if (Done) begin
                done_at.push_back(i);
                check($sformatf("b2b.result%0d", done_at.size()),
                      {31'd0, Overflow, ProductHigh, ProductLow}, {31'd0, 1'b1, 16'h0001, 16'h5F90});
            end
            if (i == 50) Start = 1'b0;
            @(negedge Clock);
        end
        check("b2b.done_count", 64'(done_at.size()), 64'd3);
        if (done_at.size() == 3) begin
            check("b2b.first_done", 64'(done_at[0]), 64'd16);
            check("b2b.period1", 64'(done_at[1] - done_at[0]), 64'd17);
            check("b2b.period2", 64'(done_at[2] - done_at[1]), 64'd17);
        end
        check("b2b.busy_vs_done", 64'(busy_bad), 64'd0);
        check("b2b.idle_after", {62'd0, Busy, Done}, 64'd0);

        // Reset in RUN cycle 8: immediate clear, no Done, clean restart.
        start_op(16'd1000, 16'd1000, 1'b0);
        repeat (7) @(negedge Clock);
        Reset = 1'b1;
        #1 check("midrst.outputs", {Busy, Done, Overflow, ProductHigh, ProductLow}, 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        busy_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (Done) dones++;
            if (Busy) busy_bad = 1'b1;
        end
        check("midrst.no_done", 64'(dones), 64'd0);
        check("midrst.idle", 64'(busy_bad), 64'd0);
        check("midrst.product_cleared", {ProductHigh, ProductLow}, 64'd0);
        run_op("after_reset", 16'd4, 16'd4, 1'b0, 16'h0000, 16'h0010, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
